// File: rtl/mat_feed_pkg.sv
// Shared constants and state encoding for the matrix operand feeder.
package mat_feed_pkg;
  localparam int MAT_DIM       = 4;
  localparam int WORDS_PER_MAT = 16;
  localparam int LOAD_CNT_W    = 5;
  localparam int IDX_W         = 4;

  typedef enum logic [1:0] {LOAD, ISSUE, DONE} state_t;
endpackage

// File: rtl/complex_matrix_bank.sv
// 4x4 complex register file: one write port, combinational row or column read.
module complex_matrix_bank
  import mat_feed_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter bit COL_READ   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_WIDTH-1:0]         wr_r,
  input  logic [DATA_WIDTH-1:0]         wr_i,
  input  logic [1:0]                    rd_sel,
  output logic [MAT_DIM*DATA_WIDTH-1:0] rd_r,
  output logic [MAT_DIM*DATA_WIDTH-1:0] rd_i
);
  // Entry address is {row, col}.
  logic [WORDS_PER_MAT-1:0][DATA_WIDTH-1:0] mem_r, mem_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r <= '0;
      mem_i <= '0;
    end else if (wr_en) begin
      mem_r[wr_idx] <= wr_r;
      mem_i[wr_idx] <= wr_i;
    end
  end

  for (genvar k = 0; k < MAT_DIM; k++) begin : g_rd
    localparam logic [1:0] K = 2'(k);
    logic [IDX_W-1:0] addr;
    assign addr = COL_READ ? {K, rd_sel} : {rd_sel, K};
    assign rd_r[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[addr];
    assign rd_i[k*DATA_WIDTH +: DATA_WIDTH] = mem_i[addr];
  end
endmodule

// File: rtl/matrix_operand_feeder.sv
// Buffers complex matrices A and B from a serial stream, then issues the 16
// (A row, B column) operand pairs in row-major result order.
module matrix_operand_feeder
  import mat_feed_pkg::*;
#(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 10,
  parameter int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_r,
  input  logic [DATA_WIDTH-1:0]         in_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAT_DIM*DATA_WIDTH-1:0] a_row_r,
  output logic [MAT_DIM*DATA_WIDTH-1:0] a_row_i,
  output logic [MAT_DIM*DATA_WIDTH-1:0] b_col_r,
  output logic [MAT_DIM*DATA_WIDTH-1:0] b_col_i,
  output logic [1:0]                    out_row,
  output logic [1:0]                    out_col,
  output logic                          out_last,
  output logic                          done
);
  localparam logic [LOAD_CNT_W-1:0] LAST_WORD = LOAD_CNT_W'(2*WORDS_PER_MAT - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORDS_PER_MAT - 1);

  state_t                  state, state_nxt;
  logic [LOAD_CNT_W-1:0]   load_cnt, load_cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    a_we, b_we;
  logic [MAT_DIM*DATA_WIDTH-1:0] a_rd_r, a_rd_i, b_rd_r, b_rd_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      load_cnt <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      load_cnt <= load_cnt_nxt;
      idx      <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_cnt_nxt = load_cnt;
    idx_nxt      = idx;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_cnt_nxt = load_cnt + 1'b1;
          if (load_cnt == LAST_WORD) begin
            load_cnt_nxt = '0;
            state_nxt    = ISSUE;
          end
        end
      end
      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          idx_nxt = idx + 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Load-count MSB splits the stream: words 0..15 fill A, 16..31 fill B.
  assign a_we = (state == LOAD) && in_valid && !load_cnt[LOAD_CNT_W-1];
  assign b_we = (state == LOAD) && in_valid &&  load_cnt[LOAD_CNT_W-1];

  complex_matrix_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b0)) u_bank_a (
    .clk(clk), .rst(rst), .wr_en(a_we), .wr_idx(load_cnt[IDX_W-1:0]),
    .wr_r(in_r), .wr_i(in_i), .rd_sel(idx[3:2]), .rd_r(a_rd_r), .rd_i(a_rd_i)
  );

  complex_matrix_bank #(.DATA_WIDTH(DATA_WIDTH), .COL_READ(1'b1)) u_bank_b (
    .clk(clk), .rst(rst), .wr_en(b_we), .wr_idx(load_cnt[IDX_W-1:0]),
    .wr_r(in_r), .wr_i(in_i), .rd_sel(idx[1:0]), .rd_r(b_rd_r), .rd_i(b_rd_i)
  );

  assign a_row_r  = out_valid ? a_rd_r : '0;
  assign a_row_i  = out_valid ? a_rd_i : '0;
  assign b_col_r  = out_valid ? b_rd_r : '0;
  assign b_col_i  = out_valid ? b_rd_i : '0;
  assign out_row  = out_valid ? idx[3:2] : 2'b00;
  assign out_col  = out_valid ? idx[1:0] : 2'b00;
  assign out_last = out_valid && (idx == LAST_IDX);
endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Scoreboard bench: loads matrix pairs, predicts the 16 operand beats from the
// matrices, and a negedge monitor compares every presented beat.
module tb_matrix_operand_feeder;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [DW-1:0] in_r, in_i;
  logic [4*DW-1:0] a_row_r, a_row_i, b_col_r, b_col_i;
  logic [1:0]    out_row, out_col;

  matrix_operand_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
    .a_row_r(a_row_r), .a_row_i(a_row_i), .b_col_r(b_col_r), .b_col_i(b_col_i),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  row, col;
    logic        last;
    logic [63:0] ar, ai, br, bi;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] ma_r[4][4], ma_i[4][4], mb_r[4][4], mb_i[4][4];
  int          vectors = 0, errors = 0, popped = 0;
  bit          mon_en = 0, exp_done = 0, exp_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] v = 16'($urandom);
    if (v == 16'h7FFF) v = 16'h0;
    return v;
  endfunction

  // Reference: C[i][j] needs row i of A and column j of B, row-major order.
  function automatic void push_expected();
    beat_t b;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        b = '0;
        b.row  = 2'(i);
        b.col  = 2'(j);
        b.last = (i == 3 && j == 3);
        for (int k = 0; k < 4; k++) begin
          b.ar[k*16 +: 16] = ma_r[i][k];
          b.ai[k*16 +: 16] = ma_i[i][k];
          b.br[k*16 +: 16] = mb_r[k][j];
          b.bi[k*16 +: 16] = mb_i[k][j];
        end
        exp_q.push_back(b);
      end
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma_r[i][j] = rnd16(); ma_i[i][j] = rnd16();
        mb_r[i][j] = rnd16(); mb_i[i][j] = rnd16();
      end
  endfunction

  beat_t e;
  always @(negedge clk) if (mon_en) begin
    chk("done", done, exp_done);
    if (exp_rdy) chk("in_ready_after_done", in_ready, 1);
    exp_rdy  = exp_done;
    exp_done = 0;
    if (out_valid) begin
      chk("in_ready_in_issue", in_ready, 0);
      if (exp_q.size() == 0) chk("stale_beat", out_valid, 0);
      else begin
        e = exp_q[0];
        chk("out_row", out_row, e.row);
        chk("out_col", out_col, e.col);
        chk("out_last", out_last, e.last);
        chk("a_row_r", a_row_r, e.ar);
        chk("a_row_i", a_row_i, e.ai);
        chk("b_col_r", b_col_r, e.br);
        chk("b_col_i", b_col_i, e.bi);
        if (out_ready) begin
          void'(exp_q.pop_front());
          popped++;
          if (e.last) exp_done = 1;
        end
      end
    end else begin
      chk("idle_a_row_r", a_row_r, 0);
      chk("idle_b_col_i", b_col_i, 0);
      chk("idle_index", {out_row, out_col, out_last}, 0);
    end
  end

  task automatic wait_load();
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk("reach_load", in_ready, 1);
  endtask

  task automatic load_mats(input bit gaps);
    int k = 0, guard = 0;
    while (k < 32 && guard < 1000) begin
      in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_r = (k < 16) ? ma_r[k/4][k%4] : mb_r[(k-16)/4][(k-16)%4];
      in_i = (k < 16) ? ma_i[k/4][k%4] : mb_i[(k-16)/4][(k-16)%4];
      @(posedge clk); #1; guard++;
      if (in_valid) k++;
    end
    in_valid = 0;
    chk("load_words", k, 32);
    push_expected();
    chk("latency_out_valid", out_valid, 1);
  endtask

  // mode 0: ready always; 1: stall 3 cycles at beat 5; 2: random ready; 3: reset at beat 7
  task automatic drain(input int mode);
    int  start = popped, cyc = 0;
    bit  stalled = 0;
    in_valid = 1; in_r = 16'h7FFF; in_i = 16'h7FFF;
    while (popped - start < 16 && cyc < 400) begin
      if (mode == 1 && popped - start == 5 && !stalled) begin
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1; cyc += 3; stalled = 1;
      end
      if (mode == 3 && popped - start == 7) begin
        out_ready = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        exp_q.delete(); exp_done = 0; exp_rdy = 0;
        chk("mid_issue_reset_in_ready", in_ready, 1);
        chk("mid_issue_reset_out_valid", out_valid, 0);
        return;
      end
      out_ready = (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 0;
    chk("drain_beats", popped - start, 16);
    if (mode == 0) chk("throughput_cycles", cyc, 16);
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; in_r = 0; in_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_flags", {out_last, done}, 0);
    chk("reset_a_row_r", a_row_r, 0);
    chk("reset_b_col_r", b_col_r, 0);
    rst = 0;
    mon_en = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
    end

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma_r[i][j] = (i == j) ? 16'h0400 : 16'h0000;
        ma_i[i][j] = 16'h0000;
        mb_r[i][j] = 16'(16*i + j);
        mb_i[i][j] = 16'h0100;
      end
    load_mats(0);
    chk("first_a_row_r", a_row_r, 64'h0000_0000_0000_0400);
    chk("first_b_col_r", b_col_r, 64'h0030_0020_0010_0000);
    chk("first_b_col_i", b_col_i, 64'h0100_0100_0100_0100);
    drain(0);
    wait_load();

    load_mats(1);
    drain(1);
    wait_load();

    fill_random();
    load_mats(1);
    drain(3);

    fill_random();
    load_mats(0);
    drain(2);
    wait_load();

    for (int r = 0; r < 4; r++) begin
      fill_random();
      load_mats(1);
      drain(2);
      wait_load();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/matrix_operand_feeder.md
Name: matrix_operand_feeder

Overview:
- Upstream source for the complex element-extraction datapath.
- Accepts two 4x4 complex Q6.10 matrices, A then B, as a serial stream and buffers them.
- Then issues all 16 (row of A, column of B) operand pairs in row-major result order, so each beat yields one result element C[i][j].
- One beat per cycle, with valid/ready backpressure on the issue side.

Parameters:
- INTEGER_SIZE, 6, integer bits of each fixed-point component.
- FRACT_SIZE, 10, fractional bits of each fixed-point component.
- DATA_WIDTH, INTEGER_SIZE+FRACT_SIZE (16), width of one real or imaginary component.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  feeder accepts an input word.
- in_r  in  DATA_WIDTH  real part of the input element.
- in_i  in  DATA_WIDTH  imaginary part of the input element.
- out_valid  out  1  operand pair valid.
- out_ready  in  1  downstream accepts the pair.
- a_row_r  out  4*DATA_WIDTH  real parts of A[i][0..3]; element k at [k*DATA_WIDTH +: DATA_WIDTH].
- a_row_i  out  4*DATA_WIDTH  imaginary parts of A[i][0..3]; same packing.
- b_col_r  out  4*DATA_WIDTH  real parts of B[0..3][j]; element k = B[k][j].
- b_col_i  out  4*DATA_WIDTH  imaginary parts of B[0..3][j]; same packing.
- out_row  out  2  result row index i.
- out_col  out  2  result column index j.
- out_last  out  1  high on the beat with i=3, j=3.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Interface fixed: one clock clk; rst synchronous, active-high, checked only at posedge clk.
- Handshake: a transfer occurs on a cycle where valid and ready are both high at posedge clk.

Reset:
- state=LOAD, load count=0, issue index=0.
- All storage zeroed.
- in_ready=1; out_valid, out_last, done=0; all data and index outputs 0.

FSM states: LOAD, ISSUE, DONE.
- LOAD:
  - in_ready=1.
  - Each input handshake writes word k (5-bit load count, 0..31).
  - Words 0..15 go to A[k/4][k%4]; words 16..31 go to B[(k-16)/4][(k-16)%4] (both row-major).
  - On the handshake of word 31: load count→0, go to ISSUE.
- ISSUE:
  - in_ready=0; input words offered are ignored and storage is unchanged.
  - out_valid=1. Outputs are A row i and B column j, selected by a registered 4-bit issue index (i = index[3:2], j = index[1:0]).
  - On out_ready=1: index increments.
  - On out_ready=0: all outputs hold stable; no beat is skipped or repeated.
  - On the handshake with index=15 (out_last=1): index→0, go to DONE.
- DONE:
  - Exactly one cycle; done=1, out_valid=0, in_ready=0.
  - Then go to LOAD; a new matrix pair can be loaded. Storage is overwritten, not cleared.

Output and timing rules:
- Data, index and out_last outputs read 0 whenever out_valid=0.
- Latency: out_valid rises the cycle after the word-31 handshake.
- Throughput: with out_ready held high, the 16 beats take 16 consecutive cycles.
- No arithmetic is performed; components are passed through bit-exact in signed Q(INTEGER_SIZE).(FRACT_SIZE).
- rst asserted in any state, including mid-load or mid-issue, takes priority over any simultaneous handshake. The next cycle shows reset values, and any partial load is discarded.

Decomposition:
- Package mat_feed_pkg holds:
  - MAT_DIM=4, WORDS_PER_MAT=16, LOAD_CNT_W=5, IDX_W=4.
  - State enum {LOAD, ISSUE, DONE}.
- Sub-module complex_matrix_bank, instanced twice (A and B):
  - 4x4 complex register file with one write port (index, r, i) and synchronous reset to zero.
  - Combinational read of a whole row (used for A) or a whole column (used for B), selected by a 2-bit index.
- Top level holds the FSM, the counters and output gating.

Test Plan:
- Reset → in_ready=1, out_valid=0, every data output 0x0; then hold in_valid=0 for 5 cycles → state unchanged.
- Load A=identity (diagonal r=0x0400 i.e. 1.0, all else 0) and B[k][l].r=16k+l, B[k][l].i=0x0100 → first beat out_row=0, out_col=0, a_row_r={0,0,0,0x0400}, b_col_r={0x30,0x20,0x10,0x00}, b_col_i all 0x0100.
- Same load with out_ready=1 throughout → 16 consecutive beats in (i,j) order 00,01..33; out_last only on beat 16; done pulses the following cycle; in_ready=1 one cycle later.
- out_ready=0 for 3 cycles at beat 5 (i=1, j=0) → out_row/out_col/data stable for all 3 cycles; the next accepted beat after release is i=1, j=1.
- in_valid=1 with in_r=0x7FFF throughout ISSUE → in_ready=0; the next matrix pair issued after reload contains no 0x7FFF unless it was loaded.
- rst for one cycle during beat 7, then a fresh load of 32 words with new values → first beat shows the new A row 0 / B column 0; no stale beats are emitted.
